stream_mux_rr: RTL and testbench

Parametrised N-input, WIDTH-bit streaming multiplexer with a registered output stage and valid/ready handshakes on every input and on the output. It replaces the fixed 8-to-1 combinational select with two modes: fixed-channel select via `sel`, and round-robin arbitration across all valid inputs. It sits between multiple producers, such as ALU result sources or load/store return paths, and a single downstream consumer.

---
 rtl/stream_mux_rr_if.sv | 26 ++
 rtl/stream_mux_rr.sv | 83 ++++++++
 tb/tb_stream_mux_rr.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the stream mux, and one consumer.
interface stream_mux_rr_if #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = 3
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-input streaming mux with fixed-select or round-robin arbitration and a
// single registered output stage; in_ready never depends on in_data.
module stream_mux_rr #(
    parameter int WIDTH = 32,
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input logic           clock,
    input logic           reset,
    stream_mux_rr_if.slave bus
);
    logic                 load_en;
    logic                 sel_ok;
    logic [N-1:0]         grant;
    logic [SEL_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [SEL_W-1:0]     scan_idx;
    logic [WIDTH-1:0]     grant_data;
    logic                 xfer;

    logic [WIDTH-1:0]     data_p0;
    logic [SEL_W-1:0]     chan_p0;
    logic                 vld_p0;
    logic [SEL_W-1:0]     last;

    assign load_en = !vld_p0 || bus.out_ready;
    assign sel_ok  = ({1'b0, bus.sel} < (SEL_W+1)'(N));

    // Round-robin scans last+1 .. last+N, so the previous winner ranks lowest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        if (!bus.mode) begin
            if (sel_ok && bus.in_valid[bus.sel]) begin
                grant[bus.sel] = 1'b1;
                grant_idx      = bus.sel;
                grant_any      = 1'b1;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                scan_idx = SEL_W'((int'(last) + k) % N);
                if (!grant_any && bus.in_valid[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    grant_idx       = scan_idx;
                    grant_any       = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) grant_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    assign xfer         = grant_any && load_en;
    assign bus.in_ready = load_en ? grant : '0;

    // Output stage p0: the only register between producers and consumer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_p0 <= '0;
            chan_p0 <= '0;
            vld_p0  <= 1'b0;
            last    <= SEL_W'(N - 1);
        end else if (xfer) begin
            data_p0 <= grant_data;
            chan_p0 <= grant_idx;
            vld_p0  <= 1'b1;
            if (bus.mode) last <= grant_idx;
        end else if (bus.out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.out_data  = data_p0;
    assign bus.out_chan  = chan_p0;
    assign bus.out_valid = vld_p0;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_stream_mux_rr;
    localparam int W  = 32;
    localparam int NC = 8;
    localparam int SW = 3;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    stream_mux_rr_if #(.WIDTH(W), .N(NC), .SEL_W(SW)) bus ();

    stream_mux_rr #(.WIDTH(W), .N(NC), .SEL_W(SW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Model state: what the output register must hold.
    bit              m_valid;
    logic [W-1:0]    m_data;
    int              m_chan;
    int              m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel that wins this cycle under the arbitration rules, or -1.
    function automatic int model_grant();
        int c;
        if (!bus.mode) begin
            if (int'(bus.sel) < NC && bus.in_valid[bus.sel]) return int'(bus.sel);
            return -1;
        end
        for (int k = 1; k <= NC; k++) begin
            c = (m_last + k) % NC;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clock or posedge reset) begin
        int g;
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_last  = NC - 1;
        end else begin
            g = model_grant();
            if (g >= 0 && (!m_valid || bus.out_ready)) begin
                m_data  = bus.in_data[g*W +: W];
                m_chan  = g;
                m_valid = 1'b1;
                if (bus.mode) m_last = g;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        int g;
        logic [NC-1:0] exp_ready;
        #2;
        g = model_grant();
        exp_ready = '0;
        if (g >= 0 && (!m_valid || bus.out_ready)) exp_ready[g] = 1'b1;
        chk("cyc_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("cyc_data",  64'(bus.out_data),  64'(m_data));
        chk("cyc_chan",  64'(bus.out_chan),  64'(m_chan));
        chk("cyc_ready", 64'(bus.in_ready),  64'(exp_ready));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [W-1:0] v);
        bus.in_data[ch*W +: W] = v;
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Load one word so reset has something to clear.
        bus.mode     = 1'b1;
        bus.in_valid = 8'h10;
        set_data(4, 32'h4444_4444);
        tick();
        chk("warm_chan", 64'(bus.out_chan), 64'd4);
        chk("warm_data", 64'(bus.out_data), 64'h4444_4444);

        #2 reset = 1'b1;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data",  64'(bus.out_data),  64'd0);
        chk("rst_chan",  64'(bus.out_chan),  64'd0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < NC; i++) set_data(i, 32'hC0DE_0000 + i);
        bus.mode      = 1'b1;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rr_chan", 64'(bus.out_chan), 64'(i % 8));
            chk("rr_data", 64'(bus.out_data), 64'(32'hC0DE_0000 + (i % 8)));
        end

        bus.in_valid = 8'b1000_0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_sparse", 64'(bus.out_chan), (i % 2 == 0) ? 64'd2 : 64'd7);
        end

        bus.mode     = 1'b0;
        bus.sel      = 3'd5;
        bus.in_valid = 8'hFF;
        set_data(5, 32'hDEAD_BEEF);
        #1 chk("fix_ready0", 64'(bus.in_ready), 64'h20);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fix_chan",  64'(bus.out_chan), 64'd5);
            chk("fix_data",  64'(bus.out_data), 64'hDEAD_BEEF);
            chk("fix_ready", 64'(bus.in_ready), 64'h20);
        end
        set_data(5, 32'hC0DE_0005);
        bus.mode = 1'b1;
        tick();
        chk("fix_last_kept", 64'(bus.out_chan), 64'd0);

        tick();
        chk("bp_first", 64'(bus.out_chan), 64'd1);
        bus.out_ready = 1'b0;
        #1 chk("bp_ready0", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_data",  64'(bus.out_data),  64'hC0DE_0001);
            chk("bp_ready", 64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(bus.in_ready), 64'h04);
        tick();
        chk("bp_next_chan",  64'(bus.out_chan),  64'd2);
        chk("bp_next_valid", 64'(bus.out_valid), 64'd1);

        tick();
        chk("ms_rr3", 64'(bus.out_chan), 64'd3);
        bus.mode = 1'b0;
        bus.sel  = 3'd6;
        tick();
        chk("ms_fix6", 64'(bus.out_chan), 64'd6);
        bus.mode = 1'b1;
        tick();
        chk("ms_rr4", 64'(bus.out_chan), 64'd4);

        bus.mode     = 1'b0;
        bus.sel      = 3'd6;
        bus.in_valid = 8'hBF;
        #1 chk("nov_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("nov_valid", 64'(bus.out_valid), 64'd0);
        chk("nov_chan",  64'(bus.out_chan),  64'd4);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NC; i++) set_data(i, W'($urandom));
            bus.in_valid  = NC'($urandom);
            bus.mode      = ($urandom_range(0, 3) != 0);
            bus.sel       = SW'($urandom_range(0, NC - 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
